enemy_health: RTL and testbench
===============================

Name: enemy_health

Overview:
- Downstream consumer of the player's bullet stage: takes the one-cycle hit flag produced when a player bullet strikes the enemy and maintains enemy HP.
- Applies invulnerability frames with a sprite-blink flag, runs a death timer, and raises game-over / defeat indications.
- Feeds the renderer (visibility, HP bar) and the top-level game FSM (dead, defeat pulse).

Parameters:
MAX_HP, 10, starting/restart HP (1..255)
DAMAGE, 1, HP removed per accepted hit (1..255)
IFRAME_CYCLES, 30, clk cycles of invulnerability after a non-lethal hit (>=1, <65536)
DEATH_CYCLES, 60, clk cycles of death animation before DEAD (>=1, <65536)
BLINK_PERIOD, 4, clk cycles per visibility half-period while blinking (>=1, <256)

Ports:
clk  in  1  game clock, same clock as the bullet stage
rst_n  in  1  reset; synchronous, active-low
isHit  in  1  bullet-hit flag, valid every cycle, 1 = enemy struck this cycle
shield  in  1  enemy shielding; a hit while 1 is blocked
restart  in  1  level restart request, level-sensitive
hp  out  8  current HP, 0..MAX_HP
visible  out  1  1 = draw enemy sprite this cycle
alive  out  1  1 in ALIVE or HURT
dead  out  1  1 in DEAD
damaged  out  1  one-cycle pulse: a hit was accepted
blocked  out  1  one-cycle pulse: a hit was absorbed by shield
defeat  out  1  one-cycle pulse on entry to DEAD

Behaviour:
- All outputs registered; every input sampled at posedge clk; effects visible the following cycle (latency 1).
- Reset (rst_n=0 at posedge): state=ALIVE, hp=MAX_HP, timer=0, blink counter=0, visible=1, alive=1, dead=0, damaged=blocked=defeat=0. Reset mid-operation aborts any timer.
- Priority per cycle: rst_n > restart > state logic.
- restart=1 (any state): same values as reset; an isHit in that cycle is discarded.
- States: ALIVE, HURT, DYING, DEAD.
- ALIVE:
  - isHit & shield: blocked=1 next cycle; no other change.
  - isHit & !shield: damaged=1; hp' = 0 if hp<=DAMAGE else hp-DAMAGE (saturating, never wraps).
  - If hp'=0: go to DYING, timer=DEATH_CYCLES-1. Otherwise go to HURT, timer=IFRAME_CYCLES-1.
  - Blink counter cleared; visible=0 for the first BLINK_PERIOD cycles of the new state.
- HURT:
  - isHit ignored; no damaged/blocked pulse.
  - timer decrements each cycle.
  - Blink counter counts 0..BLINK_PERIOD-1; visible toggles on wrap.
  - timer=0: return to ALIVE with visible=1. Total HURT residency is exactly IFRAME_CYCLES cycles.
- DYING:
  - alive=0; hits ignored; blinks as in HURT.
  - At timer=0: go to DEAD, visible=0, dead=1, defeat=1 for exactly one cycle. Residency is DEATH_CYCLES cycles.
- DEAD: holds (hp=0, visible=0, dead=1) until restart or reset.
- damaged/blocked/defeat are high for exactly one cycle per event and never high simultaneously.
- isHit held high across cycles counts as one hit per cycle while ALIVE. The HURT entry after the first hit masks the rest.
- Timer 16 bits, blink counter 8 bits; only the two distinct counters are used; no other state.

Test Plan:
- Reset with MAX_HP=3 -> hp=3, visible=1, alive=1, dead=0, all pulses 0; after rst_n rises, no changes with isHit=0 for 100 cycles.
- MAX_HP=3, IFRAME_CYCLES=5, BLINK_PERIOD=2: isHit 1 cycle -> next cycle hp=2, damaged=1 one cycle, visible 0,0,1,1,0, then ALIVE with visible=1 after exactly 5 cycles. A second isHit in cycle 3 of HURT -> hp stays 2.
- isHit with shield=1 in ALIVE -> blocked=1 one cycle, hp unchanged at 3, state stays ALIVE.
- DAMAGE=2, hp=3: two hits separated by i-frames -> hp 1, then 0 (saturates, no wrap). DYING for DEATH_CYCLES=4 cycles, then dead=1, defeat=1 single cycle, visible=0, held for 50 cycles.
- restart asserted in the 2nd cycle of DYING together with isHit -> next cycle ALIVE, hp=MAX_HP, visible=1, no damaged pulse.
- isHit held high for 10 cycles with IFRAME_CYCLES=3 -> damaged pulses at cycles 1, 5, 9 (hit, 3 masked cycles, return to ALIVE); hp decremented 3 times.

Source files
------------

// File: rtl/enemy_health.sv
// Enemy hit-point tracker: applies bullet hits, invulnerability frames with sprite blink,
// a death timer, and the dead/defeat indications consumed by the renderer and game FSM.
module enemy_health #(
    parameter int unsigned MAX_HP        = 10,
    parameter int unsigned DAMAGE        = 1,
    parameter int unsigned IFRAME_CYCLES = 30,
    parameter int unsigned DEATH_CYCLES  = 60,
    parameter int unsigned BLINK_PERIOD  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       isHit,
    input  logic       shield,
    input  logic       restart,
    output logic [7:0] hp,
    output logic       visible,
    output logic       alive,
    output logic       dead,
    output logic       damaged,
    output logic       blocked,
    output logic       defeat
);

    typedef enum logic [1:0] {ALIVE, HURT, DYING, DEAD} state_t;

    localparam logic [7:0]  HP_FULL     = 8'(MAX_HP);
    localparam logic [7:0]  HIT_DAMAGE  = 8'(DAMAGE);
    localparam logic [15:0] IFRAME_LOAD = 16'(IFRAME_CYCLES - 1);
    localparam logic [15:0] DEATH_LOAD  = 16'(DEATH_CYCLES - 1);
    localparam logic [7:0]  BLINK_LAST  = 8'(BLINK_PERIOD - 1);

    state_t      state, state_next;
    logic [15:0] timer, timer_next;
    logic [7:0]  blink, blink_next;
    logic [7:0]  hp_next, hp_after_hit;
    logic        visible_next, alive_next, dead_next;
    logic        damaged_next, blocked_next, defeat_next;
    logic        hit_taken;

    // Saturating subtraction: a hit never wraps HP below zero.
    assign hp_after_hit = (hp <= HIT_DAMAGE) ? '0 : hp - HIT_DAMAGE;
    assign hit_taken    = isHit && !shield && (state == ALIVE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ALIVE;
            hp      <= HP_FULL;
            timer   <= '0;
            blink   <= '0;
            visible <= 1'b1;
            alive   <= 1'b1;
            dead    <= 1'b0;
            damaged <= 1'b0;
            blocked <= 1'b0;
            defeat  <= 1'b0;
        end else begin
            state   <= state_next;
            hp      <= hp_next;
            timer   <= timer_next;
            blink   <= blink_next;
            visible <= visible_next;
            alive   <= alive_next;
            dead    <= dead_next;
            damaged <= damaged_next;
            blocked <= blocked_next;
            defeat  <= defeat_next;
        end
    end

    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = ALIVE;
        end else begin
            case (state)
                ALIVE: if (hit_taken) state_next = (hp_after_hit == '0) ? DYING : HURT;
                HURT:  if (timer == '0) state_next = ALIVE;
                DYING: if (timer == '0) state_next = DEAD;
                DEAD:  state_next = DEAD;
                default: state_next = ALIVE;
            endcase
        end
    end

    always_comb begin
        hp_next      = hp;
        timer_next   = timer;
        blink_next   = blink;
        visible_next = visible;
        damaged_next = 1'b0;
        blocked_next = 1'b0;
        defeat_next  = 1'b0;
        if (restart) begin
            hp_next      = HP_FULL;
            timer_next   = '0;
            blink_next   = '0;
            visible_next = 1'b1;
        end else begin
            case (state)
                ALIVE: begin
                    if (isHit && shield) begin
                        blocked_next = 1'b1;
                    end else if (hit_taken) begin
                        damaged_next = 1'b1;
                        hp_next      = hp_after_hit;
                        timer_next   = (hp_after_hit == '0) ? DEATH_LOAD : IFRAME_LOAD;
                        blink_next   = '0;
                        visible_next = 1'b0;
                    end
                end
                HURT, DYING: begin
                    if (timer == '0) begin
                        blink_next   = '0;
                        visible_next = (state == HURT);
                        defeat_next  = (state == DYING);
                    end else begin
                        timer_next = timer - 16'd1;
                        // Visibility flips each time the blink counter wraps.
                        if (blink == BLINK_LAST) begin
                            blink_next   = '0;
                            visible_next = !visible;
                        end else begin
                            blink_next = blink + 8'd1;
                        end
                    end
                end
                DEAD: visible_next = 1'b0;
                default: visible_next = 1'b1;
            endcase
        end
        alive_next = (state_next == ALIVE) || (state_next == HURT);
        dead_next  = (state_next == DEAD);
    end

endmodule

// File: tb/tb_enemy_health.sv
// Bench for enemy_health: two differently parameterised instances share stimulus and are
// compared every cycle against a phase/elapsed-time model, plus literal expectations.
module tb_enemy_health;

    localparam int unsigned P_MAX [2] = '{3, 3};
    localparam int unsigned P_DMG [2] = '{1, 2};
    localparam int unsigned P_IF  [2] = '{5, 3};
    localparam int unsigned P_DTH [2] = '{4, 4};
    localparam int unsigned P_BP  [2] = '{2, 3};

    logic       clk = 1'b0;
    logic       rst_n, isHit, shield, restart;
    logic [7:0] hp_o [2];
    logic       vis_o [2], alive_o [2], dead_o [2], dmg_o [2], blk_o [2], def_o [2];

    int errors = 0;
    int checks = 0;

    // Model: phase 0=alive 1=invulnerable 2=dying 3=dead; el = cycles spent in phase.
    int m_hp [2], m_phase [2], m_el [2];
    int m_dmg [2], m_blk [2], m_def [2];
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        enemy_health #(
            .MAX_HP(P_MAX[g]), .DAMAGE(P_DMG[g]), .IFRAME_CYCLES(P_IF[g]),
            .DEATH_CYCLES(P_DTH[g]), .BLINK_PERIOD(P_BP[g])
        ) dut (
            .clk(clk), .rst_n(rst_n), .isHit(isHit), .shield(shield), .restart(restart),
            .hp(hp_o[g]), .visible(vis_o[g]), .alive(alive_o[g]), .dead(dead_o[g]),
            .damaged(dmg_o[g]), .blocked(blk_o[g]), .defeat(def_o[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_vis(input int i);
        if (m_phase[i] == 0) return 1;
        if (m_phase[i] == 3) return 0;
        return ((m_el[i] / P_BP[i]) % 2 == 1) ? 1 : 0;
    endfunction

    function automatic void model_step(input int i);
        int len;
        m_dmg[i] = 0;
        m_blk[i] = 0;
        m_def[i] = 0;
        if (!rst_n || restart) begin
            m_hp[i] = P_MAX[i];
            m_phase[i] = 0;
            m_el[i] = 0;
            return;
        end
        case (m_phase[i])
            0: if (isHit) begin
                if (shield) m_blk[i] = 1;
                else begin
                    m_dmg[i] = 1;
                    m_hp[i] = (m_hp[i] > P_DMG[i]) ? m_hp[i] - P_DMG[i] : 0;
                    m_phase[i] = (m_hp[i] == 0) ? 2 : 1;
                    m_el[i] = 0;
                end
            end
            1, 2: begin
                len = (m_phase[i] == 1) ? P_IF[i] : P_DTH[i];
                if (m_el[i] == len - 1) begin
                    if (m_phase[i] == 2) m_def[i] = 1;
                    m_phase[i] = (m_phase[i] == 1) ? 0 : 3;
                    m_el[i] = 0;
                end else m_el[i]++;
            end
            default: ;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        if (!rst_n) m_valid = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("hp[%0d]", i), int'(hp_o[i]), m_hp[i]);
                chk($sformatf("visible[%0d]", i), int'(vis_o[i]), m_vis(i));
                chk($sformatf("alive[%0d]", i), int'(alive_o[i]), (m_phase[i] < 2) ? 1 : 0);
                chk($sformatf("dead[%0d]", i), int'(dead_o[i]), (m_phase[i] == 3) ? 1 : 0);
                chk($sformatf("damaged[%0d]", i), int'(dmg_o[i]), m_dmg[i]);
                chk($sformatf("blocked[%0d]", i), int'(blk_o[i]), m_blk[i]);
                chk($sformatf("defeat[%0d]", i), int'(def_o[i]), m_def[i]);
            end
        end
    end

    initial begin
        int npulse;
        rst_n = 1'b0; isHit = 1'b0; shield = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hp", int'(hp_o[0]), 3);
        chk("rst_visible", int'(vis_o[0]), 1);
        chk("rst_alive", int'(alive_o[0]), 1);
        chk("rst_dead", int'(dead_o[0]), 0);
        chk("rst_pulses", int'({dmg_o[0], blk_o[0], def_o[0]}), 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_hp", int'(hp_o[0]), 3);

        // Single hit on instance 0: blink pattern 0,0,1,1,0, second hit in cycle 3 masked.
        isHit = 1'b1;
        @(negedge clk); isHit = 1'b0;
        chk("hit1_hp", int'(hp_o[0]), 2);
        chk("hit1_damaged", int'(dmg_o[0]), 1);
        chk("hit1_vis1", int'(vis_o[0]), 0);
        chk("hit1_hpB", int'(hp_o[1]), 1);
        @(negedge clk);
        chk("hit1_vis2", int'(vis_o[0]), 0);
        chk("hit1_pulse_once", int'(dmg_o[0]), 0);
        @(negedge clk); isHit = 1'b1;
        chk("hit1_vis3", int'(vis_o[0]), 1);
        @(negedge clk); isHit = 1'b0;
        chk("hit1_vis4", int'(vis_o[0]), 1);
        chk("masked_hp", int'(hp_o[0]), 2);
        @(negedge clk);
        chk("hit1_vis5", int'(vis_o[0]), 0);
        chk("hit1_still_hurt_alive", int'(alive_o[0]), 1);
        @(negedge clk);
        chk("back_alive_vis", int'(vis_o[0]), 1);

        // Shielded hit.
        isHit = 1'b1; shield = 1'b1;
        @(negedge clk); isHit = 1'b0; shield = 1'b0;
        chk("shield_blocked", int'(blk_o[0]), 1);
        chk("shield_hp", int'(hp_o[0]), 2);
        chk("shield_damaged", int'(dmg_o[0]), 0);

        // Instance 1 (DAMAGE=2, hp=1): saturating kill, death timer, defeat pulse.
        isHit = 1'b1;
        @(negedge clk); isHit = 1'b0;
        chk("kill_hp_sat", int'(hp_o[1]), 0);
        chk("kill_alive", int'(alive_o[1]), 0);
        repeat (3) @(negedge clk);
        chk("dying_not_dead", int'(dead_o[1]), 0);
        @(negedge clk);
        chk("dead_flag", int'(dead_o[1]), 1);
        chk("defeat_pulse", int'(def_o[1]), 1);
        chk("dead_vis", int'(vis_o[1]), 0);
        @(negedge clk);
        chk("defeat_once", int'(def_o[1]), 0);
        repeat (50) @(negedge clk);
        chk("dead_hold", int'(dead_o[1]), 1);

        restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        chk("restart_hp", int'(hp_o[1]), 3);

        // Restart together with a hit in the 2nd DYING cycle.
        isHit = 1'b1;
        @(negedge clk); isHit = 1'b0;
        repeat (3) @(negedge clk);
        isHit = 1'b1;
        @(negedge clk); isHit = 1'b0;
        chk("dying2_hp", int'(hp_o[1]), 0);
        @(negedge clk); restart = 1'b1; isHit = 1'b1;
        @(negedge clk); restart = 1'b0; isHit = 1'b0;
        chk("rs_hp", int'(hp_o[1]), 3);
        chk("rs_alive", int'(alive_o[1]), 1);
        chk("rs_vis", int'(vis_o[1]), 1);
        chk("rs_damaged", int'(dmg_o[1]), 0);

        // Held isHit: one accepted hit per invulnerability window.
        npulse = 0;
        isHit = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            npulse += int'(dmg_o[0]);
        end
        isHit = 1'b0;
        chk("held_pulses", npulse, 2);
        chk("held_hp", int'(hp_o[0]), 1);

        // Randomised traffic: frequent restarts, then rare ones so DEAD is reached and held.
        for (int seg = 0; seg < 2; seg++) begin
            for (int c = 0; c < 2500; c++) begin
                @(negedge clk);
                rst_n   = ($urandom_range(0, 199) != 0);
                restart = (seg == 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 299) == 0);
                isHit   = ($urandom_range(0, 2) == 0);
                shield  = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; restart = 1'b0; isHit = 1'b0; shield = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
